timing_engine_sequencer: RTL



---
 rtl/timing_engine_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/timing_engine_sequencer.sv
// Purpose: radio timing-engine sequencer (PLL enable, settle wait, guard delay, TX/RX enable, ramp-down).
// Latency: registered Moore outputs; an input sampled at edge n is reflected in the outputs after edge n.
// Backpressure: none; inputs are level signals evaluated every cycle and outputs are always valid.
module timing_engine_sequencer #(
  parameter int SIZE_SPISLAVE_T_ARSTFS = 4,
  parameter int PLL_TIMEOUT_CYCLES     = 64,
  parameter int RAMPDOWN_CYCLES        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              radioEnable,
  input  logic                              radioRxEn,
  input  logic                              pllSettled,
  input  logic [SIZE_SPISLAVE_T_ARSTFS-1:0] tArstFs,
  output logic                              pllEnable,
  output logic                              txEnable,
  output logic                              rxEnable,
  output logic                              radioReady,
  output logic                              pllTimeout,
  output logic [2:0]                        state
);

  // Timeout counter only ever reaches PLL_TIMEOUT_CYCLES-1 before leaving PLL_WAIT.
  localparam int TW = $clog2(PLL_TIMEOUT_CYCLES);
  // One down-counter is shared by the ARST guard and the ramp-down dwell.
  localparam int RW = $clog2(RAMPDOWN_CYCLES + 1);
  localparam int DW = (SIZE_SPISLAVE_T_ARSTFS > RW) ? SIZE_SPISLAVE_T_ARSTFS : RW;

  localparam logic [TW-1:0] TMO_LAST  = TW'(PLL_TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] RAMP_LOAD = DW'(RAMPDOWN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLL_WAIT = 3'd1,
    S_ARST     = 3'd2,
    S_ACTIVE   = 3'd3,
    S_RAMPDOWN = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t        cur_state, nxt_state;
  logic [TW-1:0] tmo_cnt, nxt_tmo_cnt;
  logic [DW-1:0] dly_cnt, nxt_dly_cnt;
  logic          mode, nxt_mode;
  logic          nxt_pll, nxt_tx, nxt_rx, nxt_rdy, nxt_tmo;

  // State, counters, latched mode and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= S_IDLE;
      tmo_cnt    <= '0;
      dly_cnt    <= '0;
      mode       <= 1'b0;
      pllEnable  <= 1'b0;
      txEnable   <= 1'b0;
      rxEnable   <= 1'b0;
      radioReady <= 1'b0;
      pllTimeout <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      tmo_cnt    <= nxt_tmo_cnt;
      dly_cnt    <= nxt_dly_cnt;
      mode       <= nxt_mode;
      pllEnable  <= nxt_pll;
      txEnable   <= nxt_tx;
      rxEnable   <= nxt_rx;
      radioReady <= nxt_rdy;
      pllTimeout <= nxt_tmo;
    end
  end

  // Next-state and counter update; radioEnable drop always has top priority.
  always_comb begin
    nxt_state   = cur_state;
    nxt_tmo_cnt = tmo_cnt;
    nxt_dly_cnt = dly_cnt;
    nxt_mode    = mode;
    case (cur_state)
      S_IDLE: begin
        nxt_tmo_cnt = '0;
        nxt_mode    = radioRxEn;
        if (radioEnable) nxt_state = S_PLL_WAIT;
      end
      S_PLL_WAIT: begin
        // Saturate at the terminal value so the counter can never wrap.
        if (tmo_cnt != TMO_LAST) nxt_tmo_cnt = tmo_cnt + TW'(1);
        if (!radioEnable) begin
          nxt_state   = S_RAMPDOWN;
          nxt_dly_cnt = RAMP_LOAD;
        end else if (pllSettled) begin
          // Settle beats a same-cycle timeout.
          if (tArstFs != '0) begin
            nxt_state   = S_ARST;
            nxt_dly_cnt = DW'(tArstFs) - DW'(1);
          end else begin
            nxt_state = S_ACTIVE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          nxt_state = S_ERROR;
        end
      end
      S_ARST: begin
        if (!radioEnable) begin
          nxt_state   = S_RAMPDOWN;
          nxt_dly_cnt = RAMP_LOAD;
        end else if (!pllSettled) begin
          nxt_state   = S_PLL_WAIT;
          nxt_tmo_cnt = '0;
        end else if (dly_cnt == '0) begin
          nxt_state = S_ACTIVE;
        end else begin
          nxt_dly_cnt = dly_cnt - DW'(1);
        end
      end
      S_ACTIVE: begin
        if (!radioEnable) begin
          nxt_state   = S_RAMPDOWN;
          nxt_dly_cnt = RAMP_LOAD;
        end else if (!pllSettled) begin
          nxt_state   = S_PLL_WAIT;
          nxt_tmo_cnt = '0;
        end
      end
      S_RAMPDOWN: begin
        // Runs to completion regardless of radioEnable; IDLE re-evaluates it.
        if (dly_cnt == '0) nxt_state = S_IDLE;
        else               nxt_dly_cnt = dly_cnt - DW'(1);
      end
      S_ERROR: begin
        if (!radioEnable) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Moore decode of the upcoming state, registered so outputs are glitch-free.
  always_comb begin
    nxt_pll = 1'b0;
    nxt_tx  = 1'b0;
    nxt_rx  = 1'b0;
    nxt_rdy = 1'b0;
    nxt_tmo = 1'b0;
    case (nxt_state)
      S_PLL_WAIT, S_ARST, S_RAMPDOWN: nxt_pll = 1'b1;
      S_ACTIVE: begin
        nxt_pll = 1'b1;
        nxt_rdy = 1'b1;
        nxt_tx  = ~nxt_mode;
        nxt_rx  = nxt_mode;
      end
      S_ERROR: nxt_tmo = 1'b1;
      default: nxt_pll = 1'b0;
    endcase
  end

  assign state = cur_state;

endmodule
